// File: rtl/dz_pkg.sv
// Shared types and helpers for the eyes display sequencer: state encoding,
// pattern-select values and the look-around wrap rule.
package dz_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_AUTO   = 3'd2,
        ST_BLINK  = 3'd3,
        ST_MANUAL = 3'd4
    } state_e;

    localparam logic [2:0] NUM_BLANK = 3'd0;
    localparam logic [2:0] NUM_LEFT  = 3'd1;
    localparam logic [2:0] NUM_RIGHT = 3'd2;
    localparam logic [2:0] NUM_DOWN  = 3'd3;
    localparam logic [2:0] NUM_UP    = 3'd4;

    // Look-around order is left, right, down, up, then back to left.
    function automatic logic [2:0] next_dir(input logic [2:0] dir);
        if (dir == NUM_BLANK || dir >= NUM_UP) begin
            return NUM_LEFT;
        end
        return dir + 3'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dz_ms_timer.sv
// Loadable millisecond down counter; expire is high during the cycle the count is 1.
// Load takes effect at the next edge and overrides counting; the counter parks at zero.
module dz_ms_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/dz_eyes_ctrl.sv
// Eyes display sequencer: arbitrates auto look-around with blink against manual keys.
// All outputs registered, one cycle from input sample; no backpressure (pattern select is level).
module dz_eyes_ctrl
    import dz_pkg::*;
#(
    parameter int DWELL_MS    = 500,
    parameter int HOLD_MS     = 3000,
    parameter int BLINK_MS    = 150,
    parameter int BLINK_EVERY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       auto_en,
    input  logic       key_valid,
    input  logic [2:0] key_dir,
    output logic [2:0] num,
    output logic [2:0] mode,
    output logic       step_pulse
);

    localparam int TMAX = max3(DWELL_MS, HOLD_MS, BLINK_MS);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = (BLINK_EVERY > 1) ? $clog2(BLINK_EVERY) : 1;

    localparam logic [TW-1:0] T_DWELL  = TW'(DWELL_MS);
    localparam logic [TW-1:0] T_HOLD   = TW'(HOLD_MS);
    localparam logic [TW-1:0] T_BLINK  = TW'(BLINK_MS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_EVERY - 1);

    logic [1:0]    rst_sync;
    logic          rst_core_n;

    state_e        st;
    state_e        st_n;
    logic [2:0]    num_n;
    logic [2:0]    last;
    logic [2:0]    last_n;
    logic [2:0]    nxt;
    logic [CW-1:0] step_cnt;
    logic [CW-1:0] cnt_n;
    logic          pulse_n;
    logic          key_ok;
    logic          go_next;
    logic          go_idle;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;

    // Reset asserts asynchronously but releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];

    dz_ms_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_core_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign key_ok = key_valid && (key_dir >= NUM_LEFT) && (key_dir <= NUM_UP);
    assign nxt    = next_dir(last);

    always_comb begin
        st_n     = st;
        num_n    = num;
        last_n   = last;
        cnt_n    = step_cnt;
        pulse_n  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        go_next  = 1'b0;
        go_idle  = 1'b0;

        if (!en) begin
            st_n     = ST_OFF;
            num_n    = NUM_BLANK;
            tmr_load = 1'b1;
        end else if (key_ok) begin
            st_n     = ST_MANUAL;
            num_n    = key_dir;
            last_n   = key_dir;
            tmr_load = 1'b1;
            tmr_val  = T_HOLD;
        end else begin
            case (st)
                ST_OFF: begin
                    // Waking up resumes the last pattern rather than advancing.
                    num_n = last;
                    cnt_n = '0;
                    if (auto_en) begin
                        st_n     = ST_AUTO;
                        tmr_load = 1'b1;
                        tmr_val  = T_DWELL;
                    end else begin
                        st_n = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (auto_en) begin
                        go_next = 1'b1;
                        cnt_n   = '0;
                    end
                end
                ST_AUTO: begin
                    if (tmr_expire) begin
                        if (step_cnt == CNT_LAST) begin
                            // The deferred pattern is next_dir(last), shown when the blink ends.
                            cnt_n    = '0;
                            st_n     = ST_BLINK;
                            num_n    = NUM_BLANK;
                            tmr_load = 1'b1;
                            tmr_val  = T_BLINK;
                        end else begin
                            cnt_n   = step_cnt + CW'(1);
                            go_next = 1'b1;
                        end
                    end else if (!auto_en) begin
                        go_idle = 1'b1;
                    end
                end
                ST_BLINK: begin
                    if (tmr_expire) begin
                        go_next = 1'b1;
                    end else if (!auto_en) begin
                        go_idle = 1'b1;
                    end
                end
                ST_MANUAL: begin
                    if (tmr_expire) begin
                        if (auto_en) begin
                            go_next = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end
                end
                default: begin
                    st_n     = ST_OFF;
                    num_n    = NUM_BLANK;
                    tmr_load = 1'b1;
                end
            endcase

            if (go_next) begin
                st_n     = ST_AUTO;
                num_n    = nxt;
                last_n   = nxt;
                pulse_n  = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = T_DWELL;
            end
            if (go_idle) begin
                st_n     = ST_IDLE;
                num_n    = last;
                tmr_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            st         <= ST_OFF;
            num        <= NUM_BLANK;
            last       <= NUM_LEFT;
            step_cnt   <= '0;
            step_pulse <= 1'b0;
        end else begin
            st         <= st_n;
            num        <= num_n;
            last       <= last_n;
            step_cnt   <= cnt_n;
            step_pulse <= pulse_n;
        end
    end

    assign mode = st;

    assert property (@(posedge clk) disable iff (!rst_core_n) num <= NUM_UP);
    assert property (@(posedge clk) disable iff (!rst_core_n) step_pulse |-> (st == ST_AUTO));

endmodule

// File: doc/dz_eyes_ctrl.md
# dz_eyes_ctrl

Sequencer for the 8×8 dot-matrix eyes display. Drives the 3-bit pattern select consumed by the dot-matrix scan block and arbitrates between an automatic look-around animation (with periodic blink) and manual direction requests from debounced keys. Runs on the 1 kHz display clock, so every timer count is one millisecond.

## Interface
- DWELL_MS, 500: cycles each pattern is held in auto mode (≥1)
- HOLD_MS, 3000: cycles a manual pattern is held before auto resumes (≥1)
- BLINK_MS, 150: cycles of blank display per blink (≥1)
- BLINK_EVERY, 4: auto steps between blinks (≥1)
- clk  in  1  1 kHz display clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  display enable; 0 forces blank
- auto_en  in  1  enable automatic animation
- key_valid  in  1  one-cycle manual request strobe
- key_dir  in  3  requested pattern, valid with key_valid
- num  out  3  pattern select to scan block: 0 = blank, 1 = left, 2 = right, 3 = down, 4 = up
- mode  out  3  current state encoding (from package)
- step_pulse  out  1  one-cycle pulse on each auto pattern advance

## Operation
- Reset values: num = 0, mode = OFF, step_pulse = 0, last = 1, step_cnt = 0, timer = 0.
- `last` holds the most recent non-blank pattern shown.
- States:
  - OFF: num = 0.
  - IDLE: num = last.
  - AUTO: num = sequence position.
  - BLINK: num = 0.
  - MANUAL: num = held key_dir.
- Priority, evaluated every cycle, highest first:
  1. en = 0 → OFF.
  2. Valid key (key_valid = 1 and key_dir in 1..4) → MANUAL with num = key_dir. Timer loads HOLD_MS. Repeated keys reload the timer.
  3. Timer expiry.
  4. auto_en change.
- key_dir values 0 and 5..7 are ignored entirely. num never takes a value above 4.
- OFF with en = 1 → AUTO if auto_en is 1, else IDLE.
- IDLE with auto_en rising → AUTO, starting at pattern last+1. Sequence wraps 4 → 1.
- AUTO:
  - Timer loads DWELL_MS on entry.
  - On expiry: advance pattern (1→2→3→4→1), pulse step_pulse, step_cnt++.
  - When step_cnt reaches BLINK_EVERY: clear step_cnt and go to BLINK instead of showing the next pattern.
- BLINK: timer loads BLINK_MS. On expiry → AUTO showing the pattern that was deferred.
- MANUAL: on HOLD_MS expiry → AUTO if auto_en is 1, continuing from key_dir+1 (wrapping) with step_cnt cleared. Otherwise → IDLE.
- auto_en falling in AUTO or BLINK → IDLE, showing last. The blink is abandoned.

## Timing
- All outputs are registered. An input sampled at edge t is reflected on num/mode after edge t.
- A key strobe in cycle t gives num = key_dir from cycle t+1.
- Each auto pattern is visible for exactly DWELL_MS cycles. A blink is exactly BLINK_MS cycles. A manual pattern holds exactly HOLD_MS cycles after the last key.
- step_pulse is high in the same cycle num shows the new pattern. There is no step_pulse on the BLINK entry cycle.
- Timer is a down counter of width $clog2(max(DWELL_MS, HOLD_MS, BLINK_MS)+1). Expiry occurs when the count reaches 1 on an active cycle, never by wrap.
- Simultaneous events:
  - Key and expiry in the same cycle: the key wins and the timer reloads HOLD_MS.
  - en low and key in the same cycle: OFF.
- rst_n assertion mid-operation: all state returns to reset values immediately, without waiting for clk. Release is synchronised by a two-flop reset deassertion inside the block.

## Structure
- Package dz_pkg:
  - state enum: OFF, IDLE, AUTO, BLINK, MANUAL.
  - num constants: NUM_BLANK, NUM_LEFT, NUM_RIGHT, NUM_DOWN, NUM_UP.
  - the next_dir wrap function.
- Sub-module dz_ms_timer: loadable down counter with load, load value, and one-cycle expire output. Instantiated once and shared by all states.
- FSM, arbitration, step_cnt and `last` live in the top.

## Test plan
Parameters for all scenarios: DWELL_MS = 4, HOLD_MS = 10, BLINK_MS = 2, BLINK_EVERY = 4.
- Reset, en = 1, auto_en = 1 → num = 1 for 4 cycles, then 2, 3, 4 (4 cycles each). step_pulse fires 3 times, then num = 0 for 2 cycles, then num = 1.
- In AUTO showing 2, key 4 → num = 4 next cycle for 10 cycles, then num = 1 (wrap) with step_pulse.
- auto_en = 0 and key 3 → num = 3 for 10 cycles, then IDLE with num = 3 held indefinitely. Keys 0, 5 and 7 leave num unchanged.
- Key 2 on the cycle the dwell expires → MANUAL with num = 2 and no step_pulse. A second key at hold cycle 8 extends the hold to 10 cycles from the new key.
- en low in BLINK → num = 0 and mode = OFF next cycle. en high with auto_en = 0 → IDLE with num = last non-blank pattern.
- rst_n pulsed low between clock edges mid-MANUAL → num = 0 and mode = OFF before the next edge. Restarts at num = 1.
